// File: rtl/jpeg_bit_packer.sv
// MSB-first variable-length code packer: 32-bit word FIFO, then byte serializer with JPEG 0xFF/0x00 stuffing.
// Optional build macro JPACK_OVERFLOW_FLAG_EN adds a sticky overflow output.
module jpeg_bit_packer #(
  parameter int WFIFO_DEPTH = 16,
  parameter int BFIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ilength,
  input  logic [31:0] idata,
  input  logic [31:0] inostuff,
  output logic [2:0]  rest,
  output logic        ready,
  input  logic        dequeue,
  output logic [7:0]  jpeg
`ifdef JPACK_OVERFLOW_FLAG_EN
  ,
  output logic        overflow
`endif
);

  localparam int WA = $clog2(WFIFO_DEPTH);
  localparam int BA = $clog2(BFIFO_DEPTH);
  localparam logic [WA:0] W_ONE = {{WA{1'b0}}, 1'b1};
  localparam logic [BA:0] B_ONE = {{BA{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, EMIT, STUFF} ser_state_t;

  function automatic logic [5:0] clamp_len(input logic [5:0] l);
    return (l > 6'd32) ? 6'd32 : l;
  endfunction

  function automatic logic [63:0] low_mask(input logic [5:0] l);
    return (64'd1 << l) - 64'd1;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Stage p0: bit accumulator; pending bits are right-aligned, oldest at bit cnt_p0-1
  logic [63:0] acc_p0, macc_p0;
  logic [5:0]  cnt_p0;
  logic [31:0] word_p0, wmask_p0;
  logic        vld_p0;

  logic [5:0]  len;
  logic [63:0] cat, mcat;
  logic [6:0]  total, wsh;
  logic        word_done;
  logic [5:0]  cnt_nxt;
  logic [31:0] word_nxt, wmask_nxt;

  always_comb begin
    len       = clamp_len(ilength);
    cat       = (acc_p0 << len) | ({32'd0, idata} & low_mask(len));
    mcat      = (macc_p0 << len) | ({32'd0, inostuff} & low_mask(len));
    total     = {1'b0, cnt_p0} + {1'b0, len};
    word_done = (total >= 7'd32);
    wsh       = total - 7'd32;
    word_nxt  = 32'(cat >> wsh);
    wmask_nxt = 32'(mcat >> wsh);
    cnt_nxt   = word_done ? wsh[5:0] : total[5:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      cnt_p0 <= cnt_nxt;
      vld_p0 <= word_done;
    end
    acc_p0   <= cat;
    macc_p0  <= mcat;
    word_p0  <= word_nxt;
    wmask_p0 <= wmask_nxt;
  end

  assign rest = 3'd0 - cnt_p0[2:0];

  // Stage p1: word FIFO; a word arriving while full is dropped
  logic [63:0] wmem [WFIFO_DEPTH];
  logic [WA:0] wwr, wrd;
  logic        wempty, wfull, wpush, wpop;

  assign wempty = (wwr == wrd);
  assign wfull  = (wwr[WA] != wrd[WA]) && (wwr[WA-1:0] == wrd[WA-1:0]);
  assign wpush  = vld_p0 && !wfull;

  always_ff @(posedge clk) begin
    if (rst) begin
      wwr <= '0;
      wrd <= '0;
    end else begin
      if (wpush) wwr <= wwr + W_ONE;
      if (wpop)  wrd <= wrd + W_ONE;
    end
    if (wpush) wmem[wwr[WA-1:0]] <= {word_p0, wmask_p0};
  end

  // Stage p2: serializer, one byte (or stuffed zero) per cycle
  ser_state_t  state, state_nxt;
  logic [1:0]  bidx, bidx_nxt;
  logic [31:0] sword, smask;
  logic [7:0]  cur_byte, cur_mask, bdata;
  logic        bpush, bspace, byte_done, bempty, bfull;

  always_comb begin
    state_nxt = state;
    bidx_nxt  = bidx;
    wpop      = 1'b0;
    bpush     = 1'b0;
    bdata     = 8'h00;
    byte_done = 1'b0;
    cur_byte  = byte_sel(sword, bidx);
    cur_mask  = byte_sel(smask, bidx);
    case (state)
      IDLE: begin
        if (!wempty) begin
          wpop      = 1'b1;
          bidx_nxt  = 2'd0;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (bspace) begin
          bpush = 1'b1;
          bdata = cur_byte;
          if (cur_byte == 8'hFF && cur_mask != 8'hFF) state_nxt = STUFF;
          else                                        byte_done = 1'b1;
        end
      end
      STUFF: begin
        if (bspace) begin
          bpush     = 1'b1;
          bdata     = 8'h00;
          byte_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // After the last byte, chain straight into the next word to avoid a bubble
    if (byte_done) begin
      if (bidx == 2'd3) begin
        if (!wempty) begin
          wpop      = 1'b1;
          bidx_nxt  = 2'd0;
          state_nxt = EMIT;
        end else begin
          state_nxt = IDLE;
        end
      end else begin
        bidx_nxt  = bidx + 2'd1;
        state_nxt = EMIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bidx  <= '0;
    end else begin
      state <= state_nxt;
      bidx  <= bidx_nxt;
    end
    if (wpop) {sword, smask} <= wmem[wrd[WA-1:0]];
  end

  // Stage p3: byte FIFO, first-word fall-through
  logic [7:0]  bmem [BFIFO_DEPTH];
  logic [BA:0] bwr, brd;
  logic        bpop;

  assign bempty = (bwr == brd);
  assign bfull  = (bwr[BA] != brd[BA]) && (bwr[BA-1:0] == brd[BA-1:0]);
  assign bpop   = dequeue && !bempty;
  assign bspace = !bfull || dequeue;
  assign ready  = !bempty;
  assign jpeg   = bempty ? 8'h00 : bmem[brd[BA-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      bwr <= '0;
      brd <= '0;
    end else begin
      if (bpush) bwr <= bwr + B_ONE;
      if (bpop)  brd <= brd + B_ONE;
    end
    if (bpush) bmem[bwr[BA-1:0]] <= bdata;
  end

`ifdef JPACK_OVERFLOW_FLAG_EN
  localparam int STALL_LIMIT = WFIFO_DEPTH * 8;
  localparam int SW = $clog2(STALL_LIMIT + 2);
  localparam logic [SW-1:0] STALL_TRIP = SW'(STALL_LIMIT + 1);

  logic [SW-1:0] stall_cnt;
  logic          stall;

  assign stall = (state == EMIT || state == STUFF) && !bspace;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (!stall)                       stall_cnt <= '0;
      else if (stall_cnt != STALL_TRIP) stall_cnt <= stall_cnt + {{(SW-1){1'b0}}, 1'b1};
      if ((vld_p0 && wfull) || stall_cnt == STALL_TRIP) overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Self-checking bench for jpeg_bit_packer: directed scenarios plus randomized codes against a bit-queue model.
module tb_jpeg_bit_packer;
  localparam int WFIFO_DEPTH = 16;
  localparam int BFIFO_DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ilength;
  logic [31:0] idata, inostuff;
  logic [2:0]  rest;
  logic        ready, dequeue;
  logic [7:0]  jpeg;
`ifdef JPACK_OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  jpeg_bit_packer #(.WFIFO_DEPTH(WFIFO_DEPTH), .BFIFO_DEPTH(BFIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .ilength(ilength), .idata(idata), .inostuff(inostuff),
    .rest(rest), .ready(ready), .dequeue(dequeue), .jpeg(jpeg)
`ifdef JPACK_OVERFLOW_FLAG_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain bit queue; every 32 bits become four bytes plus stuffing
  bit         mbits[$];
  bit         mmask[$];
  logic [7:0] exp_q[$];

  task automatic model_reset();
    mbits.delete();
    mmask.delete();
    exp_q.delete();
  endtask

  task automatic model_push(input int len, input logic [31:0] d, input logic [31:0] m);
    int l;
    logic [7:0] v, mk;
    l = (len > 32) ? 32 : len;
    for (int i = l - 1; i >= 0; i--) begin
      mbits.push_back(d[i]);
      mmask.push_back(m[i]);
    end
    while (mbits.size() >= 32) begin
      for (int b = 0; b < 4; b++) begin
        v = 8'h00;
        mk = 8'h00;
        for (int k = 0; k < 8; k++) begin
          v  = {v[6:0], mbits.pop_front()};
          mk = {mk[6:0], mmask.pop_front()};
        end
        exp_q.push_back(v);
        if (v == 8'hFF && mk != 8'hFF) exp_q.push_back(8'h00);
      end
    end
  endtask

  task automatic idle_inputs();
    ilength  = 6'd0;
    idata    = 32'd0;
    inostuff = 32'd0;
    dequeue  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [5:0] len, input logic [31:0] d, input logic [31:0] m);
    ilength  = len;
    idata    = d;
    inostuff = m;
    @(negedge clk);
    ilength  = 6'd0;
    idata    = 32'd0;
    inostuff = 32'd0;
  endtask

  task automatic pop_byte(output logic [7:0] b, output bit got);
    got = 1'b0;
    b   = 8'h00;
    for (int i = 0; i < 64 && !got; i++) begin
      if (ready === 1'b1) begin
        b       = jpeg;
        got     = 1'b1;
        dequeue = 1'b1;
        @(negedge clk);
        dequeue = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0h expected 0", ready); end
    n_checks++; if (jpeg !== 8'h00) begin n_fail++; $display("FAIL reset_jpeg: got %0h expected 0", jpeg); end
    n_checks++; if (rest !== 3'd0) begin n_fail++; $display("FAIL reset_rest: got %0d expected 0", rest); end
`ifdef JPACK_OVERFLOW_FLAG_EN
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0h expected 0", overflow); end
`endif
  endtask

  task automatic test_latency();
    logic [7:0] exp[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] b;
    bit got;
    do_reset();
    for (int i = 0; i < 4; i++) send(6'd8, {24'd0, exp[i]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL lat_early[%0d]: got %0h expected 0", i, ready); end
      @(negedge clk);
    end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL lat_ready: got %0h expected 1", ready); end
    for (int i = 0; i < 4; i++) begin
      pop_byte(b, got);
      n_checks++; if (!got || b !== exp[i]) begin n_fail++; $display("FAIL lat_byte[%0d]: got %0h (present %0d) expected %0h", i, b, got, exp[i]); end
    end
    repeat (8) @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL lat_empty: got %0h expected 0", ready); end
  endtask

  task automatic test_stuffing();
    logic [7:0] e1[6] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h12};
    logic [7:0] e2[5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h12};
    logic [7:0] b;
    bit got;
    do_reset();
    send(6'd32, 32'hFF00FF12, 32'h0);
    for (int i = 0; i < 6; i++) begin
      pop_byte(b, got);
      n_checks++; if (!got || b !== e1[i]) begin n_fail++; $display("FAIL stuff_byte[%0d]: got %0h (present %0d) expected %0h", i, b, got, e1[i]); end
    end
    send(6'd32, 32'hFF00FF12, 32'hFF000000);
    for (int i = 0; i < 5; i++) begin
      pop_byte(b, got);
      n_checks++; if (!got || b !== e2[i]) begin n_fail++; $display("FAIL nostuff_byte[%0d]: got %0h (present %0d) expected %0h", i, b, got, e2[i]); end
    end
    repeat (8) @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL stuff_empty: got %0h expected 0", ready); end
  endtask

  task automatic test_rest();
    logic [7:0] e1[4] = '{8'h1F, 8'hAB, 8'hCD, 8'hEF};
    logic [7:0] e2[4] = '{8'h01, 8'h89, 8'h1A, 8'h2B};
    logic [7:0] b;
    bit got;
    do_reset();
    send(6'd3, 32'h0, 32'h0);
    n_checks++; if (rest !== 3'd5) begin n_fail++; $display("FAIL rest_3: got %0d expected 5", rest); end
    send(6'd5, 32'h1F, 32'h0);
    n_checks++; if (rest !== 3'd0) begin n_fail++; $display("FAIL rest_8: got %0d expected 0", rest); end
    send(6'd12, 32'hABC, 32'h0);
    n_checks++; if (rest !== 3'd4) begin n_fail++; $display("FAIL rest_20: got %0d expected 4", rest); end
    send(6'd12, 32'hDEF, 32'h0);
    n_checks++; if (rest !== 3'd0) begin n_fail++; $display("FAIL rest_32: got %0d expected 0", rest); end
    send(6'd8, 32'h01, 32'h0);
    n_checks++; if (rest !== 3'd0) begin n_fail++; $display("FAIL rest_40: got %0d expected 0", rest); end
    for (int i = 0; i < 4; i++) begin
      pop_byte(b, got);
      n_checks++; if (!got || b !== e1[i]) begin n_fail++; $display("FAIL rest_byte[%0d]: got %0h (present %0d) expected %0h", i, b, got, e1[i]); end
    end
    repeat (8) @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rest_partial_held: got %0h expected 0", ready); end
    send(6'd1, 32'h1, 32'h0);
    n_checks++; if (rest !== 3'd7) begin n_fail++; $display("FAIL rest_9: got %0d expected 7", rest); end
    // ilength 40 is out of range and must behave as 32
    send(6'd40, 32'h12345678, 32'h0);
    n_checks++; if (rest !== 3'd7) begin n_fail++; $display("FAIL rest_clamp: got %0d expected 7", rest); end
    for (int i = 0; i < 4; i++) begin
      pop_byte(b, got);
      n_checks++; if (!got || b !== e2[i]) begin n_fail++; $display("FAIL clamp_byte[%0d]: got %0h (present %0d) expected %0h", i, b, got, e2[i]); end
    end
  endtask

  task automatic test_random();
    int len, p;
    logic [31:0] d, m;
    logic [2:0] exp_rest;
    logic [7:0] e, b;
    bit got;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      p = mbits.size();
      exp_rest = 3'((8 - (p % 8)) % 8);
      n_checks++; if (rest !== exp_rest) begin n_fail++; $display("FAIL rnd_rest[%0d]: got %0d expected %0d", c, rest, exp_rest); end
      if (ready === 1'b1 && ($urandom % 4) != 0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra_byte[%0d]: got %0h expected none", c, jpeg);
        end else begin
          e = exp_q.pop_front();
          if (jpeg !== e) begin n_fail++; $display("FAIL rnd_byte[%0d]: got %0h expected %0h", c, jpeg, e); end
        end
        dequeue = 1'b1;
      end else begin
        dequeue = 1'b0;
      end
      if (($urandom % 5) == 0) begin
        len = (($urandom % 8) == 0) ? 33 + int'($urandom % 31) : 1 + int'($urandom % 32);
        d = (($urandom % 3) == 0) ? 32'hFFFFFFFF : $urandom;
        m = (($urandom % 4) == 0) ? 32'hFFFFFFFF : 32'h0;
        ilength = 6'(len); idata = d; inostuff = m;
        model_push(len, d, m);
      end else begin
        ilength = 6'd0; idata = 32'd0; inostuff = 32'd0;
      end
      @(negedge clk);
    end
    idle_inputs();
    p = mbits.size();
    if (p > 0) begin
      send(6'(32 - p), 32'hFFFFFFFF, 32'h0);
      model_push(32 - p, 32'hFFFFFFFF, 32'h0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(b, got);
      n_checks++; if (!got || b !== e) begin n_fail++; $display("FAIL rnd_drain: got %0h (present %0d) expected %0h", b, got, e); end
      if (!got) exp_q.delete();
    end
    repeat (10) @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rnd_empty: got %0h expected 0", ready); end
    n_checks++; if (rest !== 3'd0) begin n_fail++; $display("FAIL rnd_rest_end: got %0d expected 0", rest); end
`ifdef JPACK_OVERFLOW_FLAG_EN
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rnd_overflow: got %0h expected 0", overflow); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    bit got;
    int waited;
    do_reset();
    send(6'd32, 32'h11223344, 32'h0);
    send(6'd32, 32'h55667788, 32'h0);
    send(6'd32, 32'h99AABBCC, 32'h0);
    send(6'd5, 32'h1F, 32'h0);
    waited = 0;
    while (ready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_queued: got %0h expected 1", ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %0h expected 0", ready); end
    n_checks++; if (rest !== 3'd0) begin n_fail++; $display("FAIL mid_rest: got %0d expected 0", rest); end
    n_checks++; if (jpeg !== 8'h00) begin n_fail++; $display("FAIL mid_jpeg: got %0h expected 0", jpeg); end
    for (int i = 0; i < 4; i++) send(6'd8, 32'hA5, 32'h0);
    for (int i = 0; i < 4; i++) begin
      pop_byte(b, got);
      n_checks++; if (!got || b !== 8'hA5) begin n_fail++; $display("FAIL mid_byte[%0d]: got %0h (present %0d) expected a5", i, b, got); end
    end
    repeat (12) @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_empty: got %0h expected 0", ready); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    bit got;
    int nbytes;
    do_reset();
    repeat (WFIFO_DEPTH + BFIFO_DEPTH / 4 + 4) send(6'd32, 32'h0, 32'h0);
    repeat (60) @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready: got %0h expected 1", ready); end
    n_checks++; if (jpeg !== 8'h00) begin n_fail++; $display("FAIL ovf_head: got %0h expected 0", jpeg); end
`ifdef JPACK_OVERFLOW_FLAG_EN
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0h expected 1", overflow); end
    repeat (200) @(negedge clk);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0h expected 1", overflow); end
`endif
    nbytes = 0;
    do begin
      pop_byte(b, got);
      if (got) begin
        nbytes++;
        n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL ovf_byte[%0d]: got %0h expected 0", nbytes, b); end
      end
    end while (got && nbytes < 400);
    n_checks++;
    if (nbytes < BFIFO_DEPTH + 4 || nbytes > BFIFO_DEPTH + 4 * (WFIFO_DEPTH + 1) || (nbytes % 4) != 0) begin
      n_fail++; $display("FAIL ovf_count: got %0d expected multiple of 4 in [%0d,%0d]", nbytes, BFIFO_DEPTH + 4, BFIFO_DEPTH + 4 * (WFIFO_DEPTH + 1));
    end
`ifdef JPACK_OVERFLOW_FLAG_EN
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drain: got %0h expected 1", overflow); end
    do_reset();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0h expected 0", overflow); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_latency();
    test_stuffing();
    test_rest();
    test_random();
    test_reset_mid();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
